// File: rtl/oled_pwr_seq.sv
// oled_pwr_seq
//   Power-up / power-down sequencer for an SSD1306 OLED panel. Switches the
//   VDD, RES and VBAT rails in datasheet order and feeds the panel init
//   command bytes to the SPI byte transmitter. Every wait is counted in
//   ticks from the external delay_gen block.
//
//   Optional feature macro: OLED_SEQ_TIMEOUT_EN
//     defined   : tx_ready stall watchdog (TO_CYCLES clk) -> latched FAULT.
//     undefined : SEND waits forever for tx_ready, err is tied low.
//
// Ports
//   clk       in   system clock
//   arst_n    in   asynchronous active-low reset
//   start     in   level, begin power-up (honoured only in IDLE)
//   stop      in   level, begin power-down (honoured only in READY)
//   del_en    out  delay_gen enable, high only in WAIT states
//   delay     in   one-cycle tick pulse from delay_gen
//   tx_data   out  command byte to SPI transmitter
//   tx_valid  out  byte valid, held until tx_ready
//   tx_ready  in   SPI transmitter accepts a byte
//   dc        out  data/command select, always command (0)
//   vdd_n     out  logic rail enable, active low
//   vbat_n    out  panel rail enable, active low
//   res_n     out  panel reset, active low
//   ready     out  init complete, panel on
//   busy      out  sequence in progress
//   err       out  timeout fault flag
module oled_pwr_seq #(
   parameter int T_VDD_MS  = 1,
   parameter int T_RES_MS  = 1,
   parameter int T_VBAT_MS = 100,
   parameter int TO_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       start,
   input  logic       stop,
   output logic       del_en,
   input  logic       delay,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       dc,
   output logic       vdd_n,
   output logic       vbat_n,
   output logic       res_n,
   output logic       ready,
   output logic       busy,
   output logic       err
);

   localparam int MAX_A = (T_VDD_MS > T_RES_MS) ? T_VDD_MS : T_RES_MS;
   localparam int MAX_T = (MAX_A > T_VBAT_MS) ? MAX_A : T_VBAT_MS;
   localparam int CNT_W = $clog2(MAX_T + 1);

   // Last ROM index of each SEND group
   localparam logic [3:0] END_G0 = 4'd0;
   localparam logic [3:0] END_G1 = 4'd4;
   localparam logic [3:0] END_G2 = 4'd11;
   localparam logic [3:0] END_PD = 4'd12;

   if (T_VDD_MS < 1 || T_RES_MS < 1 || T_VBAT_MS < 1 || TO_CYCLES < 1) begin : g_param_check
      $error("oled_pwr_seq: wait lengths and TO_CYCLES must be >= 1");
   end

   typedef enum logic [4:0] {
      S_IDLE, S_VDD_ON, S_W_VDD, S_SEND0, S_RES_LO, S_W_RESLO, S_RES_HI,
      S_W_RESHI, S_SEND1, S_VBAT_ON, S_W_VBAT, S_SEND2, S_READY, S_PD_SEND,
      S_W_PD
`ifdef OLED_SEQ_TIMEOUT_EN
      , S_FAULT
`endif
   } state_t;

   function automatic logic [7:0] rom_byte(input logic [3:0] a);
      case (a)
         4'd0:    rom_byte = 8'hAE;   // display off
         4'd1:    rom_byte = 8'h8D;   // charge pump
         4'd2:    rom_byte = 8'h14;
         4'd3:    rom_byte = 8'hD9;   // pre-charge
         4'd4:    rom_byte = 8'hF1;
         4'd5:    rom_byte = 8'h81;   // contrast
         4'd6:    rom_byte = 8'h0F;
         4'd7:    rom_byte = 8'hA1;   // segment remap
         4'd8:    rom_byte = 8'hC8;   // COM scan direction
         4'd9:    rom_byte = 8'hDA;   // COM pins
         4'd10:   rom_byte = 8'h20;
         4'd11:   rom_byte = 8'hAF;   // display on
         4'd12:   rom_byte = 8'hAE;   // power-down: display off
         default: rom_byte = 8'h00;
      endcase
   endfunction

   state_t             r_state, w_state_next;
   logic [3:0]         r_idx, w_idx_next;
   logic [CNT_W-1:0]   r_cnt, w_cnt_next, w_wait_len;
   logic               w_is_wait, w_is_send, w_accept, w_wait_done;
   logic               r_vdd_n, r_vbat_n, r_res_n, r_tx_valid, r_del_en, r_ready, r_busy, r_err;
   logic [7:0]         r_tx_data, w_tx_data_next;
   logic               w_vdd_n_next, w_vbat_n_next, w_res_n_next, w_tx_valid_next;
   logic               w_del_en_next, w_ready_next, w_busy_next, w_err_next;

   // Classify the current state: wait length for WAIT states
   always_comb begin
      w_is_wait  = 1'b0;
      w_is_send  = 1'b0;
      w_wait_len = '0;
      case (r_state)
         S_W_VDD:                    begin w_is_wait = 1'b1; w_wait_len = CNT_W'(T_VDD_MS);  end
         S_W_RESLO, S_W_RESHI:       begin w_is_wait = 1'b1; w_wait_len = CNT_W'(T_RES_MS);  end
         S_W_VBAT, S_W_PD:           begin w_is_wait = 1'b1; w_wait_len = CNT_W'(T_VBAT_MS); end
         S_SEND0, S_SEND1, S_SEND2,
         S_PD_SEND:                  w_is_send = 1'b1;
         default: ;
      endcase
   end

   assign w_accept    = w_is_send & r_tx_valid & tx_ready;
   assign w_wait_done = w_is_wait & delay & (r_cnt == w_wait_len - 1'b1);

`ifdef OLED_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYCLES + 1);
   logic [TO_W-1:0] r_to_cnt, w_to_next;
   logic            w_to_hit;

   // Counts only stalled SEND cycles; any accept or non-SEND state clears it
   always_comb begin
      w_to_next = '0;
      w_to_hit  = 1'b0;
      if (w_is_send && r_tx_valid && !tx_ready) begin
         w_to_next = r_to_cnt + 1'b1;
         w_to_hit  = (r_to_cnt == TO_W'(TO_CYCLES - 1));
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) r_to_cnt <= '0;
      else         r_to_cnt <= w_to_next;
   end
`endif

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_cnt_next   = '0;                       // non-WAIT states keep the counter cleared
      if (w_is_wait && !w_wait_done)
         w_cnt_next = delay ? r_cnt + 1'b1 : r_cnt;
      if (w_accept)
         w_idx_next = r_idx + 1'b1;
      case (r_state)
         S_IDLE:    begin
                       w_idx_next = '0;
                       if (start) w_state_next = S_VDD_ON;
                    end
         S_VDD_ON:  w_state_next = S_W_VDD;
         S_W_VDD:   if (w_wait_done) w_state_next = S_SEND0;
         S_SEND0:   if (w_accept && r_idx == END_G0) w_state_next = S_RES_LO;
         S_RES_LO:  w_state_next = S_W_RESLO;
         S_W_RESLO: if (w_wait_done) w_state_next = S_RES_HI;
         S_RES_HI:  w_state_next = S_W_RESHI;
         S_W_RESHI: if (w_wait_done) w_state_next = S_SEND1;
         S_SEND1:   if (w_accept && r_idx == END_G1) w_state_next = S_VBAT_ON;
         S_VBAT_ON: w_state_next = S_W_VBAT;
         S_W_VBAT:  if (w_wait_done) w_state_next = S_SEND2;
         S_SEND2:   if (w_accept && r_idx == END_G2) w_state_next = S_READY;
         S_READY:   if (stop) w_state_next = S_PD_SEND;
         S_PD_SEND: if (w_accept && r_idx == END_PD) w_state_next = S_W_PD;
         S_W_PD:    if (w_wait_done) w_state_next = S_IDLE;
`ifdef OLED_SEQ_TIMEOUT_EN
         S_FAULT:   w_state_next = S_FAULT;
`endif
         default:   w_state_next = S_IDLE;
      endcase
`ifdef OLED_SEQ_TIMEOUT_EN
      if (w_to_hit) w_state_next = S_FAULT;
`endif
   end

   // Outputs are decoded from the next state so they register in step with it
   always_comb begin
      w_vdd_n_next    = 1'b0;
      w_vbat_n_next   = 1'b1;
      w_res_n_next    = 1'b1;
      w_tx_valid_next = 1'b0;
      w_del_en_next   = 1'b0;
      w_ready_next    = 1'b0;
      w_busy_next     = 1'b1;
      w_err_next      = 1'b0;
      case (w_state_next)
         S_IDLE:              begin w_vdd_n_next = 1'b1; w_busy_next = 1'b0; end
         S_W_VDD, S_W_RESHI,
         S_W_PD:              w_del_en_next = 1'b1;
         S_RES_LO:            w_res_n_next = 1'b0;
         S_W_RESLO:           begin w_res_n_next = 1'b0; w_del_en_next = 1'b1; end
         S_SEND0, S_SEND1:    w_tx_valid_next = 1'b1;
         S_VBAT_ON:           w_vbat_n_next = 1'b0;
         S_W_VBAT:            begin w_vbat_n_next = 1'b0; w_del_en_next = 1'b1; end
         S_SEND2, S_PD_SEND:  begin w_vbat_n_next = 1'b0; w_tx_valid_next = 1'b1; end
         S_READY:             begin w_vbat_n_next = 1'b0; w_ready_next = 1'b1; w_busy_next = 1'b0; end
`ifdef OLED_SEQ_TIMEOUT_EN
         S_FAULT:             begin
                                 w_vdd_n_next = 1'b1;
                                 w_res_n_next = 1'b0;
                                 w_err_next   = 1'b1;
                                 w_busy_next  = 1'b0;
                              end
`endif
         default: ;
      endcase
      w_tx_data_next = w_tx_valid_next ? rom_byte(w_idx_next) : 8'h00;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_vdd_n    <= 1'b1;
         r_vbat_n   <= 1'b1;
         r_res_n    <= 1'b1;
         r_tx_valid <= 1'b0;
         r_tx_data  <= 8'h00;
         r_del_en   <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_idx      <= w_idx_next;
         r_cnt      <= w_cnt_next;
         r_vdd_n    <= w_vdd_n_next;
         r_vbat_n   <= w_vbat_n_next;
         r_res_n    <= w_res_n_next;
         r_tx_valid <= w_tx_valid_next;
         r_tx_data  <= w_tx_data_next;
         r_del_en   <= w_del_en_next;
         r_ready    <= w_ready_next;
         r_busy     <= w_busy_next;
         r_err      <= w_err_next;
      end
   end

   assign vdd_n    = r_vdd_n;
   assign vbat_n   = r_vbat_n;
   assign res_n    = r_res_n;
   assign tx_valid = r_tx_valid;
   assign tx_data  = r_tx_data;
   assign del_en   = r_del_en;
   assign ready    = r_ready;
   assign busy     = r_busy;
   assign err      = r_err;
   assign dc       = 1'b0;

endmodule

// File: tb/tb_oled_pwr_seq.sv
// tb_oled_pwr_seq
//   Scoreboard bench for oled_pwr_seq: expected command bytes are queued when
//   a sequence is started and popped as the DUT hands bytes to the SPI side.
module tb_oled_pwr_seq;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, delay = 1'b0, tx_ready = 1'b0;
   logic       del_en, tx_valid, dc, vdd_n, vbat_n, res_n, ready, busy, err;
   logic [7:0] tx_data;

   oled_pwr_seq #(
      .T_VDD_MS(1), .T_RES_MS(1), .T_VBAT_MS(100), .TO_CYCLES(16)
   ) dut (
      .clk(clk), .arst_n(arst_n), .start(start), .stop(stop),
      .del_en(del_en), .delay(delay), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .dc(dc), .vdd_n(vdd_n), .vbat_n(vbat_n),
      .res_n(res_n), .ready(ready), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  up_bytes [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                  8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
   int          pulse_cnt  = 0;   // delay ticks seen while del_en is high
   int          pulse_mark = 0;   // pulse_cnt at the most recent byte accept
   bit          pulses_on  = 1'b0;
   int          rdy_mode   = 0;   // 0: always ready, 1: one cycle in three, 2: never
   int          div = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_up(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(up_bytes[i]);
   endtask

   // Input drivers: delay tick every 10 clk, tx_ready pattern per rdy_mode
   always @(posedge clk) begin
      #1;
      div   = (div == 9) ? 0 : div + 1;
      delay = pulses_on && (div == 9);
      cyc++;
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = (cyc % 3 == 0);
         default: tx_ready = 1'b0;
      endcase
   end

   // Output monitor / scoreboard
   logic [7:0] prev_data = 8'h00;
   bit         prev_pend = 1'b0;
   logic [7:0] e_byte;
   always @(negedge clk) begin
      if (del_en && delay) pulse_cnt++;
      if (prev_pend && tx_valid) chk("hold_data", tx_data, prev_data);
      if (tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_byte", exp_q.size(), 1);
         end else begin
            e_byte = exp_q.pop_front();
            chk("byte", tx_data, e_byte);
            $display("[TB] byte %02h accepted (expected %02h)", tx_data, e_byte);
            if (e_byte == 8'hF1) chk("vbat_before_f1", vbat_n, 1);
            if (e_byte == 8'h81) begin
               chk("vbat_after_f1", vbat_n, 0);
               chk("vbat_wait_pulses", pulse_cnt - pulse_mark, 100);
            end
         end
         pulse_mark = pulse_cnt;
         prev_pend  = 1'b0;
      end else begin
         prev_pend = tx_valid;
      end
      prev_data = tx_data;
   end

   task automatic wait_ready(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (ready) begin ok = 1'b1; break; end
      end
      chk(tag, ok, 1);
   endtask

   task automatic wait_vdd_off(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (vdd_n) begin ok = 1'b1; break; end
      end
      chk(tag, ok, 1);
      chk({tag, "_pulses"}, pulse_cnt - pulse_mark, 100);
   endtask

   task automatic drive(input logic s, input logic p);
      @(posedge clk); #1;
      start = s;
      stop  = p;
   endtask

   initial begin
      bit ok;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vdd_n", vdd_n, 1);     chk("rst_vbat_n", vbat_n, 1);
      chk("rst_res_n", res_n, 1);     chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0); chk("rst_del_en", del_en, 0);
      chk("rst_ready", ready, 0);     chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);         chk("rst_dc", dc, 0);
      @(posedge clk); #1 arst_n = 1'b1;

      // Stray ticks in IDLE change nothing
      pulses_on = 1'b1;
      repeat (30) @(negedge clk);
      chk("idle_busy", busy, 0); chk("idle_vdd_n", vdd_n, 1); chk("idle_del_en", del_en, 0);

      // Power-up, tx_ready always high
      push_up(12);
      drive(1'b1, 1'b0);
      wait_ready("pu1_ready");
      chk("pu1_busy", busy, 0); chk("pu1_vdd_n", vdd_n, 0);
      chk("pu1_vbat_n", vbat_n, 0); chk("pu1_res_n", res_n, 1);
      chk("pu1_queue", exp_q.size(), 0);
      drive(1'b0, 1'b0);

      // Power-down with a stuttering tx_ready
      rdy_mode = 1;
      exp_q.push_back(8'hAE);
      drive(1'b0, 1'b1);
      wait_vdd_off("pd1_vdd_off");
      chk("pd1_busy", busy, 0); chk("pd1_vbat_n", vbat_n, 1);
      chk("pd1_ready", ready, 0); chk("pd1_queue", exp_q.size(), 0);
      drive(1'b0, 1'b0);

      // start and stop together: power-up completes, then power-down
      push_up(12);
      exp_q.push_back(8'hAE);
      drive(1'b1, 1'b1);
      wait_ready("pu2_ready");
      drive(1'b0, 1'b0);
      wait_vdd_off("pd2_vdd_off");
      chk("pd2_busy", busy, 0); chk("pd2_queue", exp_q.size(), 0);

      // Reset during the VBAT wait
      rdy_mode = 0;
      push_up(5);
      drive(1'b1, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (del_en && !vbat_n) begin ok = 1'b1; break; end
      end
      chk("vbat_wait_seen", ok, 1);
      repeat (20) @(negedge clk);
      #2 arst_n = 1'b0;
      #1;
      chk("arst_vdd_n", vdd_n, 1);       chk("arst_vbat_n", vbat_n, 1);
      chk("arst_tx_valid", tx_valid, 0); chk("arst_ready", ready, 0);
      chk("arst_del_en", del_en, 0);     chk("arst_queue", exp_q.size(), 0);
      start = 1'b0;
      @(posedge clk); #1 arst_n = 1'b1;
      push_up(12);
      drive(1'b1, 1'b0);
      wait_ready("pu3_ready");
      chk("pu3_queue", exp_q.size(), 0);
      drive(1'b0, 1'b0);

      // tx_ready held low at the first byte
      #2 arst_n = 1'b0;
      rdy_mode = 2;
      @(posedge clk); #1 arst_n = 1'b1;
      drive(1'b1, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx_valid) begin ok = 1'b1; break; end
      end
      chk("stall_valid_seen", ok, 1);
      chk("stall_data", tx_data, 8'hAE);
`ifdef OLED_SEQ_TIMEOUT_EN
      repeat (15) @(negedge clk);
      chk("to_err_early", err, 0);
      @(negedge clk);
      chk("to_err", err, 1);           chk("to_vdd_n", vdd_n, 1);
      chk("to_vbat_n", vbat_n, 1);     chk("to_res_n", res_n, 0);
      chk("to_tx_valid", tx_valid, 0); chk("to_ready", ready, 0);
      drive(1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("to_err_sticky", err, 1);
`else
      repeat (40) @(negedge clk);
      chk("stall_err", err, 0);
      chk("stall_still_valid", tx_valid, 1);
      chk("stall_data_held", tx_data, 8'hAE);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
